// File: rtl/alu_result_checker.sv
// alu_result_checker: passive monitor for the pipelined alu. Delays each
// issued {valid, op, A, B} to line up with the ALU output, recomputes the
// expected result, and reports mismatches with counters and a first-failure
// capture. Never drives the ALU.
//
// state | meaning
// ------+---------------------------------------------------------------
// RUN   | checking every aligned issue (reset state)
// HALT  | stopped after first mismatch (HALT_ON_ERROR=1), left by reset only
module alu_result_checker #(
    parameter int WORD_WIDTH    = 36,
    parameter int OPCODE_WIDTH  = 4,
    parameter int ALU_LATENCY   = 4,
    parameter int COUNT_WIDTH   = 16,
    parameter int HALT_ON_ERROR = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic [OPCODE_WIDTH-1:0] op_in,
    input  logic [WORD_WIDTH-1:0]   A,
    input  logic [WORD_WIDTH-1:0]   B,
    input  logic [WORD_WIDTH-1:0]   R,
    input  logic [OPCODE_WIDTH-1:0] op_out,
    output logic                    check_valid,
    output logic                    mismatch,
    output logic                    fail,
    output logic                    halted,
    output logic [COUNT_WIDTH-1:0]  check_count,
    output logic [COUNT_WIDTH-1:0]  error_count,
    output logic [COUNT_WIDTH-1:0]  skip_count,
    output logic [OPCODE_WIDTH-1:0] fail_op,
    output logic [WORD_WIDTH-1:0]   fail_expected,
    output logic [WORD_WIDTH-1:0]   fail_got
);

    localparam logic [OPCODE_WIDTH-1:0] OP_XOR = OPCODE_WIDTH'(0);
    localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(1);
    localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(2);
    localparam logic [OPCODE_WIDTH-1:0] OP_SRL = OPCODE_WIDTH'(3);
    localparam logic [OPCODE_WIDTH-1:0] OP_SRA = OPCODE_WIDTH'(4);
    localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(5);
    localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(6);
    localparam logic [OPCODE_WIDTH-1:0] OP_YES = OPCODE_WIDTH'(7);
    localparam logic [OPCODE_WIDTH-1:0] OP_MLO = OPCODE_WIDTH'(8);
    localparam logic [OPCODE_WIDTH-1:0] OP_MHI = OPCODE_WIDTH'(9);

    typedef enum logic {ST_RUN, ST_HALT} state_t;

    state_t                  state;
    logic [ALU_LATENCY-1:0]  pipe_valid;
    logic [OPCODE_WIDTH-1:0] pipe_op [ALU_LATENCY];
    logic [WORD_WIDTH-1:0]   pipe_a  [ALU_LATENCY];
    logic [WORD_WIDTH-1:0]   pipe_b  [ALU_LATENCY];

    logic                    last_valid;
    logic [OPCODE_WIDTH-1:0] last_op;
    logic [WORD_WIDTH-1:0]   last_a;
    logic [WORD_WIDTH-1:0]   last_b;
    logic [2*WORD_WIDTH-1:0] product;
    logic [WORD_WIDTH-1:0]   exp_r;
    logic                    exp_known;
    logic                    diff;

    assign last_valid = pipe_valid[ALU_LATENCY-1];
    assign last_op    = pipe_op[ALU_LATENCY-1];
    assign last_a     = pipe_a[ALU_LATENCY-1];
    assign last_b     = pipe_b[ALU_LATENCY-1];
    assign product    = {{WORD_WIDTH{1'b0}}, last_a} * {{WORD_WIDTH{1'b0}}, last_b};
    assign diff       = (R != exp_r) || (op_out != last_op);

    function automatic logic [COUNT_WIDTH-1:0] sat_inc(input logic [COUNT_WIDTH-1:0] v);
        return (&v) ? v : v + COUNT_WIDTH'(1);
    endfunction

    // Delay line: only the valid bits need reset, payload just follows along.
    always_ff @(posedge clock) begin
        pipe_valid[0] <= reset ? 1'b0 : in_valid;
        pipe_op[0]    <= op_in;
        pipe_a[0]     <= A;
        pipe_b[0]     <= B;
        for (int i = 1; i < ALU_LATENCY; i++) begin
            pipe_valid[i] <= reset ? 1'b0 : pipe_valid[i-1];
            pipe_op[i]    <= pipe_op[i-1];
            pipe_a[i]     <= pipe_a[i-1];
            pipe_b[i]     <= pipe_b[i-1];
        end
    end

    // Reference result for the issue in the last delay stage.
    always_comb begin
        exp_known = 1'b1;
        exp_r     = '0;
        case (last_op)
            OP_XOR:  exp_r = last_a ^ last_b;
            OP_AND:  exp_r = last_a & last_b;
            OP_OR:   exp_r = last_a | last_b;
            OP_SRL:  exp_r = {1'b0, last_a[WORD_WIDTH-1:1]};
            OP_SRA:  exp_r = {last_a[WORD_WIDTH-1], last_a[WORD_WIDTH-1:1]};
            OP_ADD:  exp_r = last_a + last_b;
            OP_SUB:  exp_r = last_a - last_b;
            OP_YES:  exp_r = last_a;
            OP_MLO:  exp_r = product[WORD_WIDTH-1:0];
            OP_MHI:  exp_r = product[2*WORD_WIDTH-1:WORD_WIDTH];
            default: exp_known = 1'b0;
        endcase
    end

    // Check FSM with registered pulses, saturating counters and first-fail capture.
    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= ST_RUN;
            check_valid   <= 1'b0;
            mismatch      <= 1'b0;
            fail          <= 1'b0;
            halted        <= 1'b0;
            check_count   <= '0;
            error_count   <= '0;
            skip_count    <= '0;
            fail_op       <= '0;
            fail_expected <= '0;
            fail_got      <= '0;
        end else begin
            check_valid <= 1'b0;
            mismatch    <= 1'b0;
            case (state)
                ST_RUN: begin
                    if (last_valid) begin
                        if (exp_known) begin
                            check_valid <= 1'b1;
                            mismatch    <= diff;
                            check_count <= sat_inc(check_count);
                            if (diff) begin
                                error_count <= sat_inc(error_count);
                                fail        <= 1'b1;
                                if (!fail) begin
                                    fail_op       <= last_op;
                                    fail_expected <= exp_r;
                                    fail_got      <= R;
                                end
                                if (HALT_ON_ERROR != 0) begin
                                    state  <= ST_HALT;
                                    halted <= 1'b1;
                                end
                            end
                        end else begin
                            skip_count <= sat_inc(skip_count);
                        end
                    end
                end
                ST_HALT: begin
                    halted <= 1'b1;
                end
                default: state <= ST_RUN;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_result_checker.sv
// Bench for alu_result_checker: two instances (free-running and halt-on-error)
// fed by an emulated ALU, checked every cycle against a cycle-indexed model.
module tb_alu_result_checker;

    localparam int W  = 36;
    localparam int OW = 4;
    localparam int L  = 4;
    localparam int CW = 6;
    localparam int MAXC = (1 << CW) - 1;

    localparam logic [OW-1:0] XOR_ = 0, AND_ = 1, OR_ = 2, SRL_ = 3, SRA_ = 4;
    localparam logic [OW-1:0] ADD_ = 5, SUB_ = 6, YES_ = 7, MLO_ = 8, MHI_ = 9;

    typedef struct packed {
        logic          cv;
        logic          mm;
        logic          fail;
        logic          halted;
        int            cc;
        int            ec;
        int            sc;
        logic [OW-1:0] fop;
        logic [W-1:0]  fexp;
        logic [W-1:0]  fgot;
    } mstate_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [OW-1:0] op_in = '0;
    logic [W-1:0]  A = '0, B = '0, R = '0;
    logic [OW-1:0] op_out = '0;

    logic          cv0, mm0, fl0, hl0, cv1, mm1, fl1, hl1;
    logic [CW-1:0] cc0, ec0, sc0, cc1, ec1, sc1;
    logic [OW-1:0] fop0, fop1;
    logic [W-1:0]  fe0, fg0, fe1, fg1;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;
    int last_reset = 0;
    int cv_seen = 0;
    mstate_t m0 = '0, m1 = '0;

    logic          hv  [32];
    logic [OW-1:0] hop [32];
    logic [W-1:0]  ha  [32];
    logic [W-1:0]  hb  [32];
    logic [W-1:0]  sr  [32];
    logic [OW-1:0] sop [32];

    always #5 clock = ~clock;

    alu_result_checker #(.WORD_WIDTH(W), .OPCODE_WIDTH(OW), .ALU_LATENCY(L),
                         .COUNT_WIDTH(CW), .HALT_ON_ERROR(0)) dut0 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .op_in(op_in),
        .A(A), .B(B), .R(R), .op_out(op_out),
        .check_valid(cv0), .mismatch(mm0), .fail(fl0), .halted(hl0),
        .check_count(cc0), .error_count(ec0), .skip_count(sc0),
        .fail_op(fop0), .fail_expected(fe0), .fail_got(fg0));

    alu_result_checker #(.WORD_WIDTH(W), .OPCODE_WIDTH(OW), .ALU_LATENCY(L),
                         .COUNT_WIDTH(CW), .HALT_ON_ERROR(1)) dut1 (
        .clock(clock), .reset(reset), .in_valid(in_valid), .op_in(op_in),
        .A(A), .B(B), .R(R), .op_out(op_out),
        .check_valid(cv1), .mismatch(mm1), .fail(fl1), .halted(hl1),
        .check_count(cc1), .error_count(ec1), .skip_count(sc1),
        .fail_op(fop1), .fail_expected(fe1), .fail_got(fg1));

    function automatic logic [W-1:0] alu_ref(input logic [OW-1:0] op,
                                             input logic [W-1:0] a, input logic [W-1:0] b);
        logic [2*W-1:0] p;
        p = a;
        p = p * b;
        case (op)
            XOR_: return a ^ b;
            AND_: return a & b;
            OR_:  return a | b;
            SRL_: return a >> 1;
            SRA_: return W'($signed(a) >>> 1);
            ADD_: return a + b;
            SUB_: return a - b;
            YES_: return a;
            MLO_: return p[W-1:0];
            MHI_: return p[2*W-1:W];
            default: return '0;
        endcase
    endfunction

    function automatic mstate_t step(input mstate_t s, input bit halt_en, input bit chk,
                                     input logic [OW-1:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic [W-1:0] r,
                                     input logic [OW-1:0] opo);
        logic [W-1:0] e;
        s.cv = 1'b0;
        s.mm = 1'b0;
        if (chk && !s.halted) begin
            if (op <= MHI_) begin
                e = alu_ref(op, a, b);
                s.cv = 1'b1;
                s.mm = (r != e) || (opo != op);
                if (s.cc < MAXC) s.cc++;
                if (s.mm) begin
                    if (s.ec < MAXC) s.ec++;
                    if (!s.fail) begin
                        s.fop = op; s.fexp = e; s.fgot = r;
                    end
                    s.fail = 1'b1;
                    if (halt_en) s.halted = 1'b1;
                end
            end else if (s.sc < MAXC) begin
                s.sc++;
            end
        end
        return s;
    endfunction

    task automatic cmp(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s @edge %0d: got %0h expected %0h", name, edge_n, got, exp);
        end
    endtask

    task automatic cmp_all();
        cmp("d0.check_valid", 64'(cv0), 64'(m0.cv));
        cmp("d0.mismatch", 64'(mm0), 64'(m0.mm));
        cmp("d0.fail", 64'(fl0), 64'(m0.fail));
        cmp("d0.halted", 64'(hl0), 64'(m0.halted));
        cmp("d0.check_count", 64'(cc0), 64'(m0.cc));
        cmp("d0.error_count", 64'(ec0), 64'(m0.ec));
        cmp("d0.skip_count", 64'(sc0), 64'(m0.sc));
        cmp("d0.fail_op", 64'(fop0), 64'(m0.fop));
        cmp("d0.fail_expected", 64'(fe0), 64'(m0.fexp));
        cmp("d0.fail_got", 64'(fg0), 64'(m0.fgot));
        cmp("d1.check_valid", 64'(cv1), 64'(m1.cv));
        cmp("d1.mismatch", 64'(mm1), 64'(m1.mm));
        cmp("d1.fail", 64'(fl1), 64'(m1.fail));
        cmp("d1.halted", 64'(hl1), 64'(m1.halted));
        cmp("d1.check_count", 64'(cc1), 64'(m1.cc));
        cmp("d1.error_count", 64'(ec1), 64'(m1.ec));
        cmp("d1.skip_count", 64'(sc1), 64'(m1.sc));
        cmp("d1.fail_op", 64'(fop1), 64'(m1.fop));
        cmp("d1.fail_expected", 64'(fe1), 64'(m1.fexp));
        cmp("d1.fail_got", 64'(fg1), 64'(m1.fgot));
    endtask

    // One clock: advance the model on what the DUT sampled, compare, then
    // present idle inputs plus whatever ALU result is due next.
    task automatic tick();
        int e;
        bit chk;
        @(posedge clock);
        edge_n++;
        if (reset) begin
            m0 = '0;
            m1 = '0;
            last_reset = edge_n;
        end else begin
            e = edge_n - L;
            chk = (e > last_reset) && hv[e % 32];
            m0 = step(m0, 1'b0, chk, hop[e % 32], ha[e % 32], hb[e % 32], R, op_out);
            m1 = step(m1, 1'b1, chk, hop[e % 32], ha[e % 32], hb[e % 32], R, op_out);
        end
        hv[edge_n % 32]  = in_valid;
        hop[edge_n % 32] = op_in;
        ha[edge_n % 32]  = A;
        hb[edge_n % 32]  = B;
        #1;
        cmp_all();
        if (cv0) cv_seen++;
        in_valid = 1'b0;
        op_in = '0;
        A = '0;
        B = '0;
        R = sr[edge_n % 32];
        op_out = sop[edge_n % 32];
        sr[edge_n % 32] = '0;
        sop[edge_n % 32] = '0;
    endtask

    // corrupt: 0 correct ALU, 1 flip R bit 0, 2 flip op_out bit 0
    task automatic issue(input logic [OW-1:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input int corrupt);
        in_valid = 1'b1;
        op_in = op;
        A = a;
        B = b;
        sr[(edge_n + L) % 32]  = alu_ref(op, a, b) ^ W'(corrupt == 1);
        sop[(edge_n + L) % 32] = op ^ OW'(corrupt == 2);
    endtask

    task automatic drain();
        for (int i = 0; i < L + 2; i++) tick();
    endtask

    logic [OW-1:0] sw_op [10];
    logic [W-1:0]  sw_a  [10];
    logic [W-1:0]  sw_b  [10];

    initial begin
        for (int i = 0; i < 32; i++) begin
            hv[i] = 1'b0; hop[i] = '0; ha[i] = '0; hb[i] = '0; sr[i] = '0; sop[i] = '0;
        end
        sw_op = '{XOR_, AND_, OR_, SRL_, SRA_, ADD_, SUB_, YES_, MLO_, MHI_};
        sw_a  = '{36'hAAAAAAAAA, 36'hF0F0F0F0F, 36'h123456789, 36'h808080808, 36'h808080808,
                  36'hFFFFFFFFF, 36'h000000002, 36'hABCDEF012, 36'h0000FFFFF, 36'h0000FFFFF};
        sw_b  = '{36'h555555555, 36'h0FF00FF00, 36'h800000001, 36'h000000007, 36'h000000007,
                  36'h000000001, 36'h000000003, 36'h111111111, 36'h0000FFFFF, 36'h0000FFFFF};

        // Hand-computed values that pin the reference model.
        for (int i = 0; i < 10; i++) begin
            case (i)
                0: cmp("pin_xor", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'h FFFFFFFFF);
                3: cmp("pin_srl", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'h404040404);
                4: cmp("pin_sra", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'hC04040404);
                5: cmp("pin_add", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'h0);
                6: cmp("pin_sub", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'hFFFFFFFFF);
                8: cmp("pin_mlo", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'hFFFE00001);
                9: cmp("pin_mhi", 64'(alu_ref(sw_op[i], sw_a[i], sw_b[i])), 64'h00000000F);
                default: ;
            endcase
        end

        // Reset.
        reset = 1'b1;
        tick(); tick(); tick();
        reset = 1'b0;
        tick();

        // First XOR lands exactly L+1 edges after issue.
        issue(XOR_, 36'hAAAAAAAAA, 36'h555555555, 0);
        for (int i = 0; i < L; i++) tick();
        cmp("xor_not_early", 64'(cv0), 64'h0);
        tick();
        cmp("xor_check_valid", 64'(cv0), 64'h1);
        cmp("xor_mismatch", 64'(mm0), 64'h0);
        cmp("xor_check_count", 64'(cc0), 64'h1);
        drain();

        // Back-to-back op sweep through a correct ALU.
        for (int i = 0; i < 10; i++) begin
            issue(sw_op[i], sw_a[i], sw_b[i], 0);
            tick();
        end
        drain();
        cmp("sweep_check_count", 64'(cc0), 64'd11);
        cmp("sweep_error_count", 64'(ec0), 64'd0);
        cmp("sweep_fail", 64'(fl0), 64'd0);

        // Injected result error, then an opcode error.
        issue(ADD_, 36'hFFFFFFFFF, 36'h1, 1);
        drain();
        cmp("inj_fail", 64'(fl0), 64'd1);
        cmp("inj_fail_op", 64'(fop0), 64'(ADD_));
        cmp("inj_fail_expected", 64'(fe0), 64'h0);
        cmp("inj_fail_got", 64'(fg0), 64'h1);
        cmp("halt_entered", 64'(hl1), 64'd1);
        issue(SUB_, 36'h2, 36'h3, 2);
        drain();
        cmp("second_err_count", 64'(ec0), 64'd2);
        cmp("capture_hold_op", 64'(fop0), 64'(ADD_));
        cmp("capture_hold_got", 64'(fg0), 64'h1);

        // Halted instance ignores further correct issues.
        for (int i = 0; i < 5; i++) begin
            issue(sw_op[i], sw_a[i], sw_b[i], 0);
            tick();
        end
        drain();
        cmp("halt_check_count", 64'(cc1), 64'd12);
        cmp("halt_error_count", 64'(ec1), 64'd1);
        cmp("run_check_count", 64'(cc0), 64'd18);

        // Unknown opcode is skipped.
        issue(4'hF, 36'h1, 36'h2, 0);
        drain();
        cmp("skip_count", 64'(sc0), 64'd1);
        cmp("skip_no_check", 64'(cc0), 64'd18);

        // Reset with three issues in flight.
        cv_seen = 0;
        for (int i = 0; i < 3; i++) begin
            issue(ADD_, 36'(i), 36'(i), 0);
            tick();
        end
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        drain();
        cmp("flush_pulses", 64'(cv_seen), 64'd0);
        cmp("flush_check_count", 64'(cc0), 64'd0);
        cmp("flush_skip_count", 64'(sc0), 64'd0);
        issue(YES_, 36'h123, 36'h0, 0);
        drain();
        cmp("post_reset_check", 64'(cc0), 64'd1);

        // Saturate the error counter.
        for (int i = 0; i < MAXC + 3; i++) begin
            issue(ADD_, 36'hFFFFFFFFF, 36'h1, 1);
            tick();
        end
        drain();
        cmp("sat_error_count", 64'(ec0), 64'(MAXC));
        cmp("sat_check_count", 64'(cc0), 64'(MAXC));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
